// File: rtl/serial_pattern_tx.sv
// ============================================================================
//  Module   : serial_pattern_tx
//  Purpose  : Bit-serial pattern transmitter. Accepts a parallel pattern word
//             and a length through a valid/ready handshake, shifts the
//             selected bits out MSB-first (one per clock), flags the final
//             bit, then inserts a programmable idle gap.
//  Ports    : clk        - rising-edge clock
//             reset      - asynchronous active-high reset
//             pat_data   - pattern word, bits [L-1:0] transmitted
//             pat_len    - bit count; 0 or > WIDTH means WIDTH
//             pat_valid  - pattern offered
//             pat_ready  - pattern can be accepted (IDLE)
//             out_bit    - registered serial data (0 when not valid)
//             out_valid  - out_bit carries a pattern bit
//             out_last   - final bit of a pattern
//             busy       - SHIFT or GAP in progress
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module serial_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pat_data,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             pat_valid,
    output logic             pat_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    output logic             busy
);

    localparam logic [LEN_W-1:0] c_width    = LEN_W'(WIDTH);
    localparam logic [7:0]       c_gap_last = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
    localparam bit               c_has_gap  = (GAP > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sreg;
    logic [LEN_W-1:0] r_cnt;
    logic [7:0]       r_gap_cnt;

    logic [LEN_W-1:0] w_len;
    logic [WIDTH-1:0] w_aligned;

    // Effective length: zero or oversize requests send the full word.
    assign w_len = ((pat_len == '0) || (pat_len > c_width)) ? c_width : pat_len;

    // Left-justify the selected bits so the first bit to send sits at the MSB;
    // the shifter then always takes its next bit from the top.
    assign w_aligned = pat_data << (c_width - w_len);

    assign pat_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_sreg    <= '0;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (pat_valid) begin
                        // First bit goes straight to the output register; the
                        // remaining bits stay queued in the shifter.
                        out_bit   <= w_aligned[WIDTH-1];
                        out_valid <= 1'b1;
                        out_last  <= (w_len == LEN_W'(1));
                        r_sreg    <= w_aligned << 1;
                        r_cnt     <= w_len - 1'b1;
                        r_state   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    // r_cnt is the index of the bit currently on out_bit.
                    if (r_cnt == '0) begin
                        out_bit   <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (c_has_gap) begin
                            r_gap_cnt <= c_gap_last;
                            r_state   <= ST_GAP;
                        end else begin
                            r_state   <= ST_IDLE;
                        end
                    end else begin
                        out_bit  <= r_sreg[WIDTH-1];
                        out_last <= (r_cnt == LEN_W'(1));
                        r_sreg   <= r_sreg << 1;
                        r_cnt    <= r_cnt - 1'b1;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == 8'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_pattern_tx.sv
// ============================================================================
//  Module   : tb_serial_pattern_tx
//  Purpose  : Self-checking bench for serial_pattern_tx. Instance A uses
//             GAP=1 and is checked through an expected-bit queue; instance B
//             uses GAP=0 for the back-to-back bubble check. A small 101
//             Mealy detector model consumes instance A's serial stream.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_serial_pattern_tx;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic       clk;
    logic       reset;

    logic [7:0] pd_a, pd_b;
    logic [4:0] pl_a, pl_b;
    logic       pv_a, pv_b;
    logic       rdy_a, bit_a, val_a, last_a, busy_a;
    logic       rdy_b, bit_b, val_b, last_b, busy_b;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t q_a[$];

    logic [1:0] ds = 2'd0;
    logic       det_on = 1'b0;
    int         det_count = 0;

    serial_pattern_tx #(.WIDTH(8), .LEN_W(5), .GAP(1)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .pat_data  (pd_a),
        .pat_len   (pl_a),
        .pat_valid (pv_a),
        .pat_ready (rdy_a),
        .out_bit   (bit_a),
        .out_valid (val_a),
        .out_last  (last_a),
        .busy      (busy_a)
    );

    serial_pattern_tx #(.WIDTH(8), .LEN_W(5), .GAP(0)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .pat_data  (pd_b),
        .pat_len   (pl_b),
        .pat_valid (pv_b),
        .pat_ready (rdy_b),
        .out_bit   (bit_b),
        .out_valid (val_b),
        .out_last  (last_b),
        .busy      (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard for instance A: every valid bit is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            check("ready_vs_busy", 32'(rdy_a), 32'(!busy_a));
            if (val_a) begin
                if (q_a.size() == 0) begin
                    check("spurious_bit", 32'(val_a), 32'(0));
                end else begin
                    e = q_a.pop_front();
                    check("bit", 32'(bit_a), 32'(e.b));
                    check("last", 32'(last_a), 32'(e.last));
                end
            end else begin
                check("idle_bit", 32'(bit_a), 32'(0));
                check("idle_last", 32'(last_a), 32'(0));
            end
        end
    end

    // Reference 101 Mealy detector (overlapping) fed from instance A.
    always @(negedge clk) begin
        if (reset) begin
            ds <= 2'd0;
        end else begin
            if (det_on && (ds == 2'd2) && bit_a) begin
                det_count <= det_count + 1;
                check("det_on_last", 32'(last_a), 32'(1));
            end
            case (ds)
                2'd0:    ds <= bit_a ? 2'd1 : 2'd0;
                2'd1:    ds <= bit_a ? 2'd1 : 2'd2;
                default: ds <= bit_a ? 2'd1 : 2'd0;
            endcase
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic [4:0] l);
        int eff;
        eff = ((l == 5'd0) || (l > 5'd8)) ? 8 : int'(l);
        for (int i = eff - 1; i >= 0; i--) begin
            q_a.push_back('{b: d[i], last: (i == 0)});
        end
    endtask

    task automatic send_a(input logic [7:0] d, input logic [4:0] l);
        int n;
        @(negedge clk);
        pd_a = d;
        pl_a = l;
        pv_a = 1'b1;
        n = 0;
        while (!rdy_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept_timeout", 32'(n < 100), 32'(1));
        push_exp(d, l);
        @(posedge clk);
        #1 pv_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((!rdy_a || q_a.size() != 0) && n < 200);
        check("idle_timeout", 32'(n < 200), 32'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ev [7];
        logic eb [7];
        logic el [7];
        int   c;

        reset = 1'b1;
        pd_a = 8'd0; pl_a = 5'd0; pv_a = 1'b0;
        pd_b = 8'd0; pl_b = 5'd0; pv_b = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_bit", 32'(bit_a), 32'(0));
        check("rst_valid", 32'(val_a), 32'(0));
        check("rst_last", 32'(last_a), 32'(0));
        check("rst_busy", 32'(busy_a), 32'(0));
        check("rst_ready", 32'(rdy_a), 32'(1));
        reset = 1'b0;

        // Basic shift: 0x0D, 4 bits -> 1,1,0,1, then one gap, then ready.
        send_a(8'h0D, 5'd4);
        repeat (4) @(negedge clk);
        @(negedge clk);
        check("gap_valid", 32'(val_a), 32'(0));
        check("gap_ready", 32'(rdy_a), 32'(0));
        @(negedge clk);
        check("ready_after_gap", 32'(rdy_a), 32'(1));

        // Length clamps and single-bit pattern.
        send_a(8'hA5, 5'd0);
        wait_idle_a();
        send_a(8'hA5, 5'd12);
        wait_idle_a();
        send_a(8'h01, 5'd1);
        wait_idle_a();

        // Handshake discipline: valid held high, data churning mid-transfer.
        pd_a = 8'b0000_0110;
        pl_a = 5'd3;
        pv_a = 1'b1;
        check("hs_ready", 32'(rdy_a), 32'(1));
        push_exp(8'b0000_0110, 5'd3);
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            c++;
            if (rdy_a) break;
            pd_a = 8'($urandom);
        end
        check("hs_reaccept_cycle", 32'(c), 32'(5));
        pd_a = 8'h02;
        push_exp(8'h02, 5'd3);
        @(posedge clk);
        #1 pv_a = 1'b0;
        wait_idle_a();

        // Back-to-back with GAP=0 on instance B.
        ev = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        eb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        pd_b = 8'b0000_0101;
        pl_b = 5'd3;
        pv_b = 1'b1;
        check("b_ready", 32'(rdy_b), 32'(1));
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 4) pv_b = 1'b0;
            check("b2b_valid", 32'(val_b), 32'(ev[i]));
            check("b2b_bit", 32'(bit_b), 32'(eb[i]));
            check("b2b_last", 32'(last_b), 32'(el[i]));
            if (i == 3) check("b2b_bubble_ready", 32'(rdy_b), 32'(1));
        end
        @(negedge clk);
        check("b2b_after_valid", 32'(val_b), 32'(0));
        check("b2b_after_busy", 32'(busy_b), 32'(0));

        // Asynchronous reset mid-SHIFT.
        send_a(8'hFF, 5'd8);
        repeat (3) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_valid", 32'(val_a), 32'(0));
        check("arst_bit", 32'(bit_a), 32'(0));
        check("arst_last", 32'(last_a), 32'(0));
        check("arst_busy", 32'(busy_a), 32'(0));
        check("arst_ready", 32'(rdy_a), 32'(1));
        q_a.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check("post_reset_valid", 32'(val_a), 32'(0));
        end

        // End-to-end into the 101 detector model.
        det_on = 1'b1;
        send_a(8'h0D, 5'd4);
        send_a(8'h05, 5'd4);
        wait_idle_a();
        @(negedge clk);
        check("det_count", 32'(det_count), 32'(2));
        check("queue_drain", 32'(q_a.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

- Bit-serial pattern transmitter that drives stimulus and live traffic into the serial sequence detectors, including `mealy_101_detector`.
- Accepts a parallel pattern word and a length through a valid/ready handshake.
- Shifts the selected bits out one per clock, MSB-first, flags the final bit, then inserts a programmable idle gap.
- Sits between a host/CPU-side pattern source and any `in_bit`-style serial consumer.

## Interface
Parameters:
- `WIDTH`, 8, maximum pattern length in bits; legal range 2..16.
- `LEN_W`, 5, width of `pat_len`; must satisfy 2^LEN_W > WIDTH.
- `GAP`, 1, idle cycles after each pattern; 0 is legal; legal range 0..255.

Ports:
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `pat_data` in WIDTH: pattern word; bits [len-1:0] are transmitted.
- `pat_len` in LEN_W: number of bits to send; 0 or >WIDTH is treated as WIDTH.
- `pat_valid` in 1: pattern offered.
- `pat_ready` out 1: block can accept a pattern (IDLE only).
- `out_bit` out 1: serial data, registered.
- `out_valid` out 1: `out_bit` carries a pattern bit this cycle.
- `out_last` out 1: high with the final bit of a pattern.
- `busy` out 1: high in SHIFT or GAP.

## Operation
- States: IDLE, SHIFT, GAP.
- IDLE: `pat_ready`=1. When `pat_valid`&&`pat_ready` at an edge:
  - latch `pat_data` into a WIDTH-bit shift register;
  - latch the effective length L;
  - load bit counter = L-1;
  - go to SHIFT.
- SHIFT:
  - Each cycle presents `pat_data[L-1-i]` for i = 0..L-1; `out_valid`=1.
  - Counter decrements per cycle.
  - When counter = 0, `out_last`=1 and the next state is GAP if GAP>0, else IDLE.
- GAP:
  - Counts GAP cycles with `out_valid`=0, `out_bit`=0.
  - Returns to IDLE after the last gap cycle.
- `pat_data`/`pat_len` changes after acceptance are ignored. `pat_valid` outside IDLE is ignored; it is not queued.
- `out_bit`=0 whenever `out_valid`=0; it is never left at a stale value.
- Length arithmetic: effective L = (`pat_len`==0 || `pat_len`>WIDTH) ? WIDTH : `pat_len`. A length of 1 is legal: single bit with `out_last`=1.
- `busy` = (state != IDLE); `pat_ready` = (state == IDLE). Both are decoded from registered state only, never from inputs.

## Timing
- Reset values (asserted asynchronously, held while `reset`=1):
  - state IDLE, counters 0, shift register 0;
  - `out_bit`=0, `out_valid`=0, `out_last`=0, `busy`=0, `pat_ready`=1.
- Latency: a pattern accepted at edge k produces its first bit in the cycle after edge k. The bit is registered, so it is visible from edge k until edge k+1.
- Bit i is valid between edges k+i and k+i+1. `out_last` covers the bit after edge k+L-1.
- `pat_ready` re-asserts GAP+1 cycles after the `out_last` cycle begins, i.e. IDLE is entered at edge k+L+GAP.
- Throughput: one pattern per L+GAP+1 cycles. With GAP=0 there is exactly one idle bubble (the IDLE/accept cycle) between patterns.
- Reset mid-SHIFT or mid-GAP: the pattern is aborted. Outputs go to reset values asynchronously, and no `out_last` is issued for the aborted pattern.
- Handshake simultaneous with reset deassertion: at the first edge after release, a valid offer is accepted normally.

## Test plan
- **Reset:** assert `reset` mid-run at an arbitrary non-edge time.
  - Outputs drop to 0 immediately and `pat_ready`=1.
  - After release, no output until a new handshake.
- **Basic shift (WIDTH=8, GAP=1):** `pat_data`=8'h0D, `pat_len`=4.
  - `out_bit` sequence 1,1,0,1 on four consecutive cycles with `out_valid`=1.
  - `out_last` only on the 4th bit, then one cycle `out_valid`=0.
  - `pat_ready` high again on the following cycle.
- **Length clamp:**
  - `pat_len`=0 with `pat_data`=8'hA5 → 8 bits 1,0,1,0,0,1,0,1 with `out_last` on bit 8.
  - `pat_len`=12 → same behaviour.
  - `pat_len`=1 with `pat_data`=1 → single bit 1 with `out_valid` and `out_last` both high.
- **Handshake discipline:** hold `pat_valid`=1 with changing `pat_data` throughout a 3-bit transfer.
  - No second acceptance during SHIFT/GAP.
  - Transmitted bits match the data sampled at acceptance.
  - Next acceptance occurs exactly in the IDLE cycle.
- **Back-to-back (GAP=0):** two patterns 3'b101, 3'b101.
  - Output 1,0,1,-,1,0,1, where "-" is exactly one `out_valid`=0 bubble.
  - Total 7 cycles from the first bit to the last bit inclusive.
- **End-to-end:** drive `mealy_101_detector.in_bit` from `out_bit`, sending 4'b1101 then 4'b0101.
  - `detected` pulses exactly twice, each in the cycle the final 1 of each pattern is presented.
